collision_check: RTL and testbench

Sequential legality checker that sits directly downstream of the I-figure coordinate normaliser. It takes a candidate piece position as four packed (x, y) cells and checks each cell against the playfield bounds and the board row memory, one cell at a time. It reports whether the position collides. The movement/rotation controller uses the result to commit or discard a move.

---
 rtl/collision_check_pkg.sv | 24 ++
 rtl/collision_check_cell_select.sv | 29 ++
 rtl/collision_check.sv | 124 ++++++++++++
 tb/tb_collision_check.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_check_pkg.sv
// Shared definitions for the piece-legality path: playfield geometry defaults,
// checker state encoding and the packed-cell slicing helper.
package collision_check_pkg;

  localparam int CC_WIDTH   = 8;
  localparam int CC_FIELD_W = 10;
  localparam int CC_FIELD_H = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } cc_state_t;

  // Field i of a packed four-cell vector; cell 0 occupies the MSBs.
  function automatic logic [CC_WIDTH-1:0] cell_slice(
    input logic [4*CC_WIDTH-1:0] vec,
    input logic [1:0]            i
  );
    return vec[(3 - int'(i))*CC_WIDTH +: CC_WIDTH];
  endfunction

endpackage

// File: rtl/collision_check_cell_select.sv
// Picks the coordinates of the cell under test and flags it when it lies
// outside the playfield. Underflowed coordinates land in the out-of-bounds case
// because coordinates are treated as unsigned.
module cell_select
  import collision_check_pkg::*;
#(
  parameter int WIDTH   = CC_WIDTH,
  parameter int FIELD_W = CC_FIELD_W,
  parameter int FIELD_H = CC_FIELD_H
) (
  input  logic [4*WIDTH-1:0] x_vec,
  input  logic [4*WIDTH-1:0] y_vec,
  input  logic [1:0]         idx,
  output logic [WIDTH-1:0]   x_sel,
  output logic [WIDTH-1:0]   y_sel,
  output logic               oob
);

  localparam logic [WIDTH-1:0] X_LIM = WIDTH'(FIELD_W);
  localparam logic [WIDTH-1:0] Y_LIM = WIDTH'(FIELD_H);

  // Index mux (cell 0 at the MSBs) and bounds compare.
  always_comb begin
    x_sel = x_vec[(3 - int'(idx))*WIDTH +: WIDTH];
    y_sel = y_vec[(3 - int'(idx))*WIDTH +: WIDTH];
    oob   = (x_sel >= X_LIM) || (y_sel >= Y_LIM);
  end

endmodule

// File: rtl/collision_check.sv
// Sequential legality check of a four-cell piece position: each cell is tested
// against the playfield bounds and then against its board row, stopping at the
// first collision. Outputs are decoded purely from registered state.
module collision_check
  import collision_check_pkg::*;
#(
  parameter int WIDTH   = CC_WIDTH,
  parameter int FIELD_W = CC_FIELD_W,
  parameter int FIELD_H = CC_FIELD_H
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*WIDTH-1:0] rho_x,
  input  logic [4*WIDTH-1:0] rho_y,
  output logic               row_rd_en,
  output logic [WIDTH-1:0]   row_addr,
  input  logic [FIELD_W-1:0] row_data,
  output logic               busy,
  output logic               done,
  output logic               collide
);

  localparam int XI_W = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;

  cc_state_t          state;
  cc_state_t          state_nxt;
  logic [1:0]         idx;
  logic [4*WIDTH-1:0] x_lat;
  logic [4*WIDTH-1:0] y_lat;
  logic               collide_q;
  logic [WIDTH-1:0]   x_sel;
  logic [WIDTH-1:0]   y_sel;
  logic               oob;
  logic               hit;
  logic               accept;

  assign accept = (state == IDLE) && start;

  cell_select #(
    .WIDTH  (WIDTH),
    .FIELD_W(FIELD_W),
    .FIELD_H(FIELD_H)
  ) u_cell_select (
    .x_vec(x_lat),
    .y_vec(y_lat),
    .idx  (idx),
    .x_sel(x_sel),
    .y_sel(y_sel),
    .oob  (oob)
  );

  // Only consulted in WAIT, where x_sel is known to be inside the row.
  assign hit = row_data[x_sel[XI_W-1:0]];

  // Next-state decode: bounds test in ISSUE, board test in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = oob ? DONE : WAIT;
      WAIT:    state_nxt = (hit || (idx == 2'd3)) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Cell index: restarts on an accepted request, advances after a clean read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (accept) begin
      idx <= 2'd0;
    end else if ((state == WAIT) && !hit && (idx != 2'd3)) begin
      idx <= idx + 2'd1;
    end
  end

  // Result register: cleared on accept, set by either failure kind, held after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collide_q <= 1'b0;
    end else if (accept) begin
      collide_q <= 1'b0;
    end else if (((state == ISSUE) && oob) || ((state == WAIT) && hit)) begin
      collide_q <= 1'b1;
    end
  end

  // Coordinate latches: data only, captured on accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_lat <= rho_x;
      y_lat <= rho_y;
    end
  end

  // Output decode from state and latched data only.
  always_comb begin
    row_rd_en = 1'b0;
    row_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ISSUE: begin
        busy      = 1'b1;
        row_rd_en = !oob;
        row_addr  = oob ? '0 : y_sel;
      end
      WAIT:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign collide = collide_q;

endmodule

// File: tb/tb_collision_check.sv
// Directed bench for collision_check with a registered board-row memory model.
module tb_collision_check;

  localparam int WIDTH   = 8;
  localparam int FIELD_W = 10;
  localparam int FIELD_H = 20;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [4*WIDTH-1:0] rho_x;
  logic [4*WIDTH-1:0] rho_y;
  logic               row_rd_en;
  logic [WIDTH-1:0]   row_addr;
  logic [FIELD_W-1:0] row_data;
  logic               busy;
  logic               done;
  logic               collide;

  int checks   = 0;
  int failures = 0;

  logic [FIELD_W-1:0] board [FIELD_H];
  logic [WIDTH-1:0]   rd_log [$];

  collision_check #(
    .WIDTH  (WIDTH),
    .FIELD_W(FIELD_W),
    .FIELD_H(FIELD_H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rho_x    (rho_x),
    .rho_y    (rho_y),
    .row_rd_en(row_rd_en),
    .row_addr (row_addr),
    .row_data (row_data),
    .busy     (busy),
    .done     (done),
    .collide  (collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board memory: one-cycle read latency; all-ones when no read was issued.
  always @(posedge clk) begin
    if (row_rd_en) begin
      rd_log.push_back(row_addr);
      row_data <= (row_addr < FIELD_H) ? board[row_addr] : '0;
    end else begin
      row_data <= '1;
    end
  end

  task automatic clear_board();
    for (int r = 0; r < FIELD_H; r++) board[r] = '0;
  endtask

  // Issues one request and observes it; enters and leaves at #1 after an edge.
  task automatic run_check(input logic [31:0] x, input logic [31:0] y, input int poke_cyc,
                           output int done_cyc, output logic col, output logic busy1,
                           output logic done_after, output logic col_after);
    rd_log.delete();
    start = 1'b1;
    rho_x = x;
    rho_y = y;
    @(posedge clk); #1;
    start = 1'b0;
    rho_x = 32'h0505_0505;
    rho_y = 32'h0505_0505;
    busy1 = busy;
    done_cyc = -1;
    col = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == poke_cyc) begin
        start = 1'b1;
        rho_x = 32'h0001_0203;
        rho_y = 32'h0A0A_0A0A;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        col = collide;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    done_after = done;
    col_after  = collide;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    rho_x = '0;
    rho_y = '0;
    clear_board();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (collide !== 1'b0) begin failures++; $display("FAIL reset_collide got=%b exp=0", collide); end
    checks++; if (row_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", row_rd_en); end
    checks++; if (row_addr !== 8'd0) begin failures++; $display("FAIL reset_row_addr got=%0d exp=0", row_addr); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_empty_board();
    int dc; logic col, b1, da, ca;
    clear_board();
    run_check({8'd3, 8'd4, 8'd5, 8'd6}, 32'h0, 0, dc, col, b1, da, ca);
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL empty_busy_c1 got=%b exp=1", b1); end
    checks++; if (dc !== 9) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=9", dc); end
    checks++; if (col !== 1'b0) begin failures++; $display("FAIL empty_collide got=%b exp=0", col); end
    checks++; if (rd_log.size() !== 4) begin failures++; $display("FAIL empty_read_count got=%0d exp=4", rd_log.size()); end
    else begin
      checks++;
      if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== 32'h0)
        begin failures++; $display("FAIL empty_read_rows got=%h exp=00000000", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}); end
    end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL empty_done_width got=%b exp=0", da); end
  endtask

  task automatic test_board_last_cell();
    int dc; logic col, b1, da, ca;
    clear_board();
    board[5] = 10'b0000100000;
    run_check({8'd5, 8'd5, 8'd5, 8'd5}, {8'd2, 8'd3, 8'd4, 8'd5}, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 9) begin failures++; $display("FAIL board3_done_cycle got=%0d exp=9", dc); end
    checks++; if (col !== 1'b1) begin failures++; $display("FAIL board3_collide got=%b exp=1", col); end
    checks++; if (rd_log.size() !== 4) begin failures++; $display("FAIL board3_read_count got=%0d exp=4", rd_log.size()); end
    else begin
      checks++;
      if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3]} !== 32'h0203_0405)
        begin failures++; $display("FAIL board3_read_rows got=%h exp=02030405", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]}); end
    end
  endtask

  task automatic test_oob();
    int dc; logic col, b1, da, ca;
    clear_board();
    // x == FIELD_W at cell 1
    run_check({8'd3, 8'd10, 8'd0, 8'd0}, 32'h0, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 4) begin failures++; $display("FAIL oob_x_done_cycle got=%0d exp=4", dc); end
    checks++; if (col !== 1'b1) begin failures++; $display("FAIL oob_x_collide got=%b exp=1", col); end
    checks++; if (rd_log.size() !== 1) begin failures++; $display("FAIL oob_x_read_count got=%0d exp=1", rd_log.size()); end
    else begin
      checks++; if (rd_log[0] !== 8'd0) begin failures++; $display("FAIL oob_x_read_row got=%0d exp=0", rd_log[0]); end
    end
    // underflowed y at cell 0
    run_check(32'h0, {8'hFF, 8'd0, 8'd0, 8'd0}, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 2) begin failures++; $display("FAIL oob_y_done_cycle got=%0d exp=2", dc); end
    checks++; if (col !== 1'b1) begin failures++; $display("FAIL oob_y_collide got=%b exp=1", col); end
    checks++; if (rd_log.size() !== 0) begin failures++; $display("FAIL oob_y_read_count got=%0d exp=0", rd_log.size()); end
    // y == FIELD_H at cell 2
    run_check(32'h0, {8'd0, 8'd1, 8'd20, 8'd0}, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 6) begin failures++; $display("FAIL oob_yh_done_cycle got=%0d exp=6", dc); end
    checks++; if (rd_log.size() !== 2) begin failures++; $display("FAIL oob_yh_read_count got=%0d exp=2", rd_log.size()); end
    // underflowed x at cell 3
    run_check({8'd0, 8'd1, 8'd2, 8'hFF}, 32'h0, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 8) begin failures++; $display("FAIL oob_x3_done_cycle got=%0d exp=8", dc); end
    checks++; if (col !== 1'b1) begin failures++; $display("FAIL oob_x3_collide got=%b exp=1", col); end
  endtask

  task automatic test_corner_cell();
    int dc; logic col, b1, da, ca;
    clear_board();
    board[19] = 10'b1000000000;
    run_check({8'd9, 8'd0, 8'd0, 8'd0}, {8'd19, 8'd0, 8'd0, 8'd0}, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 3) begin failures++; $display("FAIL corner_done_cycle got=%0d exp=3", dc); end
    checks++; if (col !== 1'b1) begin failures++; $display("FAIL corner_collide got=%b exp=1", col); end
    checks++; if (rd_log.size() !== 1) begin failures++; $display("FAIL corner_read_count got=%0d exp=1", rd_log.size()); end
    else begin
      checks++; if (rd_log[0] !== 8'd19) begin failures++; $display("FAIL corner_read_row got=%0d exp=19", rd_log[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int dc; logic col, b1, da, ca;
    clear_board();
    board[5] = 10'b0000100000;
    // collision at cell 0, with a stray start during WAIT
    run_check({8'd5, 8'd0, 8'd0, 8'd0}, {8'd5, 8'd0, 8'd0, 8'd0}, 2, dc, col, b1, da, ca);
    checks++; if (dc !== 3) begin failures++; $display("FAIL b2b_first_done_cycle got=%0d exp=3", dc); end
    checks++; if (col !== 1'b1) begin failures++; $display("FAIL b2b_first_collide got=%b exp=1", col); end
    checks++; if (rd_log.size() !== 1) begin failures++; $display("FAIL b2b_first_read_count got=%0d exp=1", rd_log.size()); end
    checks++; if (ca !== 1'b1) begin failures++; $display("FAIL b2b_collide_held got=%b exp=1", ca); end
    checks++; if (da !== 1'b0) begin failures++; $display("FAIL b2b_stray_start_done got=%b exp=0", da); end
    // start in the idle cycle right after done
    run_check({8'd0, 8'd1, 8'd2, 8'd3}, {8'd10, 8'd10, 8'd10, 8'd10}, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 9) begin failures++; $display("FAIL b2b_second_done_cycle got=%0d exp=9", dc); end
    checks++; if (col !== 1'b0) begin failures++; $display("FAIL b2b_second_collide got=%b exp=0", col); end
  endtask

  task automatic test_reset_mid_check();
    int dc; logic col, b1, da, ca;
    int done_seen;
    clear_board();
    rd_log.delete();
    start = 1'b1;
    rho_x = {8'd3, 8'd4, 8'd5, 8'd6};
    rho_y = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    // now in cycle 4
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (collide !== 1'b0) begin failures++; $display("FAIL midrst_collide got=%b exp=0", collide); end
    checks++; if ({row_rd_en, row_addr} !== 9'd0) begin failures++; $display("FAIL midrst_read_port got=%h exp=0", {row_rd_en, row_addr}); end
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (done !== 1'b0) done_seen++;
      @(posedge clk); #1;
      if (c == 2) rst_n = 1'b1;
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_seen); end
    run_check({8'd3, 8'd4, 8'd5, 8'd6}, 32'h0, 0, dc, col, b1, da, ca);
    checks++; if (dc !== 9) begin failures++; $display("FAIL midrst_after_done_cycle got=%0d exp=9", dc); end
    checks++; if (col !== 1'b0) begin failures++; $display("FAIL midrst_after_collide got=%b exp=0", col); end
    checks++; if (rd_log.size() !== 4) begin failures++; $display("FAIL midrst_after_read_count got=%0d exp=4", rd_log.size()); end
  endtask

  initial begin
    test_reset();
    test_empty_board();
    test_board_last_cell();
    test_oob();
    test_corner_cell();
    test_back_to_back();
    test_reset_mid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
